// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with single-cycle logic/arith ops and bit-serial shifts
module alu_exec_unit #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] acc, alu_res, sh;
    logic [SHW-1:0] cnt, shamt;
    logic [3:0] sop;
    logic bad, is_shift, accept;
    assign shamt = op_b[SHW-1:0];
    assign is_shift = alu_ctrl == 4'b0100 || alu_ctrl == 4'b0101 || alu_ctrl == 4'b1000;
    assign accept = state == IDLE && in_valid;
    assign sh = sop == 4'b0100 ? {acc[WIDTH-2:0], 1'b0} :
                sop == 4'b0101 ? {1'b0, acc[WIDTH-1:1]} : {acc[WIDTH-1], acc[WIDTH-1:1]};
    always_comb begin
        alu_res = '0;
        bad = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0011: alu_res = op_a ^ op_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b1001: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            4'b0100, 4'b0101, 4'b1000: alu_res = op_a;
            default: bad = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE: next = !in_valid ? IDLE : (is_shift && shamt != '0) ? SHIFT : DONE;
            SHIFT: next = cnt == SHW'(1) ? DONE : SHIFT;
            DONE: next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            sop <= '0;
            result <= '0;
            zero <= 1'b0;
            illegal <= 1'b0;
        end else if (accept && is_shift && shamt != '0) begin
            acc <= op_a;
            cnt <= shamt;
            sop <= alu_ctrl;
        end else if (accept) begin
            result <= alu_res;
            zero <= alu_res == '0;
            illegal <= bad;
        end else if (state == SHIFT) begin
            acc <= sh;
            cnt <= cnt - 1'b1;
            if (cnt == SHW'(1)) begin
                result <= sh;
                zero <= sh == '0;
                illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus backpressure and mid-shift reset sequences
module tb_alu_exec_unit;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, zero, illegal;
    logic [3:0] alu_ctrl = '0;
    logic [31:0] op_a = '0, op_b = '0, result;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [3:0] ctrl;
        logic [31:0] a, b, res;
        logic z, ill;
        int lat;
    } vec_t;
    vec_t vecs[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        alu_ctrl = v.ctrl; op_a = v.a; op_b = v.b; in_valid = 1;
        chk({tag, " in_ready_idle"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk({tag, " in_ready_busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " result"}, result, v.res);
        chk({tag, " zero"}, zero, v.z);
        chk({tag, " illegal"}, illegal, v.ill);
        @(posedge clk); #1;
        chk({tag, " released_valid"}, out_valid, 0);
        chk({tag, " released_ready"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        vecs.push_back('{4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b1001, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0001, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0011, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1000, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 5});
        vecs.push_back('{4'b1000, 32'h40000000, 32'd2, 32'h10000000, 1'b0, 1'b0, 3});
        vecs.push_back('{4'b0100, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0, 32});
        vecs.push_back('{4'b0101, 32'h80000000, 32'd1, 32'h40000000, 1'b0, 1'b0, 2});
        vecs.push_back('{4'b0101, 32'h00001234, 32'd32, 32'h00001234, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0101, 32'h00000001, 32'd3, 32'd0, 1'b1, 1'b0, 4});
        vecs.push_back('{4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1});
        vecs.push_back('{4'b1010, 32'hDEADBEEF, 32'd1, 32'd0, 1'b1, 1'b1, 1});

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset zero", zero, 0);
        chk("reset illegal", illegal, 0);

        out_ready = 1;
        for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: a second request must wait until the XOR result is released
        out_ready = 0;
        @(negedge clk);
        alu_ctrl = 4'b0011; op_a = 32'h0000F0F0; op_b = 32'h00000FF0; in_valid = 1;
        @(posedge clk); #1;
        alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
        chk("bp first valid", out_valid, 1);
        chk("bp first result", result, 32'h0000FF00);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold result %0d", i), result, 32'h0000FF00);
            chk($sformatf("bp hold valid %0d", i), out_valid, 1);
            chk($sformatf("bp hold in_ready %0d", i), in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp release valid", out_valid, 0);
        chk("bp release in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp second valid", out_valid, 1);
        chk("bp second result", result, 32'd2);
        @(posedge clk); #1;
        chk("bp second released", out_valid, 0);

        // Reset in the middle of a long shift abandons it
        run('{4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1}, "pre_reset");
        @(negedge clk);
        alu_ctrl = 4'b0100; op_a = 32'd1; op_b = 32'd20; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("mid reset out_valid", out_valid, 0);
        chk("mid reset result", result, 0);
        chk("mid reset zero", zero, 0);
        chk("mid reset illegal", illegal, 0);
        chk("mid reset in_ready", in_ready, 1);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid reset no out_valid", seen, 0);
        run('{4'b0110, 32'd20, 32'd8, 32'd12, 1'b0, 1'b0, 1}, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by ALU control, together with two operands, and returns a registered result with zero flag. Shifts run iteratively, one bit per cycle, to save FPGA area; every other operation completes in one cycle. It sits between ALU control/register-file read and write-back, with a valid/ready handshake on each side.

## Interface
- WIDTH, 32: operand and result width in bits; power of two, at least 8.
- SHW, derived as log2(WIDTH): shift-amount width, fixed at 5 for the default WIDTH; not user-overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request; combinational from state.
- alu_ctrl  in  4  operation code (see Operation).
- op_a  in  WIDTH  first operand.
- op_b  in  WIDTH  second operand; for shifts only op_b[SHW-1:0] is used.
- out_valid  out  1  result, zero and illegal are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  registered; equals (result == 0).
- illegal  out  1  registered; the completed request used an unassigned code.

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0111 SLT (signed), 1001 SLTU, 0100 SLL, 0101 SRL, 1000 SRA.
- Any other code: result = 0, zero = 1, illegal = 1, one-cycle latency.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- SLT/SLTU: result = {WIDTH-1 zeros, compare bit}.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. On in_valid, a non-shift code or a shift with shamt = 0 loads result, zero and illegal and moves to DONE. For shamt = 0 the result is op_a.
  - IDLE, shift with shamt k > 0: loads accumulator = op_a, count = k, and the operation; moves to SHIFT.
  - SHIFT: each cycle shifts the accumulator by 1 and decrements count. SLL fills with 0; SRL fills with 0; SRA replicates the MSB. On the cycle count goes from 1 to 0, the accumulator result and zero are registered and the FSM moves to DONE.
  - DONE: out_valid = 1, outputs held stable. On out_ready, the FSM moves to IDLE.
- in_ready = 0 in SHIFT and DONE. Inputs are ignored outside the accepting cycle; operands may change freely during SHIFT.
- Reset values: state IDLE, out_valid 0, result 0, zero 0, illegal 0, in_ready 1 from the cycle after reset.
- Reset during SHIFT or DONE abandons the operation; no out_valid is produced for it.

## Timing
- Accepting edge A is the rising edge where in_valid && in_ready.
- Non-shift op, illegal code, or shamt 0: out_valid high starting the cycle after edge A (latency 1).
- Shift with shamt k: shifts happen on edges A+1 through A+k; out_valid is high after edge A+k (latency k+1). Maximum is WIDTH for shamt = WIDTH-1.
- Result release: out_valid && out_ready at edge R means out_valid = 0 and in_ready = 1 after R. The next accept can occur at edge R+1, so peak throughput is one op per 2 cycles.
- out_ready held high before out_valid is legal; the result is then released on the first DONE edge.
- out_valid low and out_ready high: no effect.
- Outputs are registered; no combinational path from inputs to result, zero or illegal. in_ready depends only on state.

## Test plan
- Reset then ADD: code 0010, a = 7, b = 5, out_ready = 1 → out_valid 1 cycle after accept, result 12, zero 0; next cycle in_ready 1.
- SUB to zero and SLT: SUB 9−9 → result 0, zero 1. SLT with a = 0xFFFFFFFF, b = 1 → 1. SLTU with the same operands → 0.
- Shifts: SRA a = 0x80000000, b = 4 → result 0xF8000000 after 5 cycles, in_ready 0 throughout. SLL a = 1, b = 31 → 0x80000000 after 32 cycles. SRL with shamt 0 → a after 1 cycle.
- Backpressure: out_ready = 0 for 6 cycles after XOR 0xF0F0 ^ 0x0FF0 → result 0xFF00 held stable, a second in_valid is not accepted. Raise out_ready → released, accept on the next edge.
- Illegal code 1111 → result 0, zero 1, illegal 1, latency 1.
- Reset asserted mid-SLL (shamt 20, cycle 5) → out_valid never rises, outputs return to reset values, in_ready 1 on the following cycle.
